// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache refill path: field widths, line size,
// refill FSM state encoding and a way-index to one-hot helper.
// No ports (package).
package cache_refill_ctrl_pkg;

    localparam int TAG_WIDTH     = 8;
    localparam int INDEX_WIDTH   = 6;
    localparam int OFFSET_WIDTH  = 2;   // word offset within a line
    localparam int WORD_WIDTH    = 32;
    localparam int WAY_NUM       = 4;
    localparam int WAY_IDX_WIDTH = 2;
    localparam int LINE_WORDS    = 2 ** OFFSET_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } refill_state_t;

    function automatic logic [WAY_NUM-1:0] way_onehot(input logic [WAY_IDX_WIDTH-1:0] idx);
        way_onehot = WAY_NUM'(1) << idx;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_way_sel_enc.sv
// Victim way priority encoder: lowest-numbered asserted replace enable wins,
// no enable asserted selects way 0.
// Ports:
//   replace_en  in  WAY_NUM        per-way replace enables
//   way_idx     out WAY_IDX_WIDTH  selected victim way index
module cache_refill_ctrl_way_sel_enc
    import cache_refill_ctrl_pkg::*;
(
    input  logic [WAY_NUM-1:0]       replace_en,
    output logic [WAY_IDX_WIDTH-1:0] way_idx
);

    always_comb begin
        way_idx = '0;
        if (replace_en[0])      way_idx = 2'd0;
        else if (replace_en[1]) way_idx = 2'd1;
        else if (replace_en[2]) way_idx = 2'd2;
        else if (replace_en[3]) way_idx = 2'd3;
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller. On a miss it latches the request, fetches the
// line base address from memory, writes each returned word into the victim way
// (merging the store word on a store miss), captures the critical word on a
// load miss, then writes the tag/dirty bit and releases the pipeline.
// In idle it also forwards store hits to the data array write port.
//
// State | meaning
// IDLE  | waiting for a miss; forwards store hits
// REQ   | mem_req held with line address until mem_ack
// FILL  | one data-array write per mem_rvalid beat
// DONE  | tag/dirty write, load_valid on load miss (1 cycle)
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   wr_r1, tag_r1, index_r1, offset_r1 request type and address fields
//   store_data_r1                      store data
//   hit_en_r1                          hit vector (store-hit forwarding only)
//   read_main_memory_en_r1             miss, refill required
//   wayN_replace_en_r1                 victim way selects
//   mem_req/mem_addr/mem_ack           line fetch request handshake
//   mem_rvalid/mem_rdata               returned line words
//   stall                              upstream pipeline hold
//   refill_we/index/offset/wdata       data-array write port
//   tag_we/tag_wdata/dirty_wdata       tag-array write port
//   load_data/load_valid               critical word for a load miss
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int BYTE_OFF = 2
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              wr_r1,
    input  logic [TAG_WIDTH-1:0]                              tag_r1,
    input  logic [INDEX_WIDTH-1:0]                            index_r1,
    input  logic [OFFSET_WIDTH-1:0]                           offset_r1,
    input  logic [WORD_WIDTH-1:0]                             store_data_r1,
    input  logic [WAY_NUM-1:0]                                hit_en_r1,
    input  logic                                              read_main_memory_en_r1,
    input  logic                                              way0_replace_en_r1,
    input  logic                                              way1_replace_en_r1,
    input  logic                                              way2_replace_en_r1,
    input  logic                                              way3_replace_en_r1,
    output logic                                              mem_req,
    output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH+BYTE_OFF-1:0] mem_addr,
    input  logic                                              mem_ack,
    input  logic                                              mem_rvalid,
    input  logic [WORD_WIDTH-1:0]                             mem_rdata,
    output logic                                              stall,
    output logic [WAY_NUM-1:0]                                refill_we,
    output logic [INDEX_WIDTH-1:0]                            refill_index,
    output logic [OFFSET_WIDTH-1:0]                           refill_offset,
    output logic [WORD_WIDTH-1:0]                             refill_wdata,
    output logic [WAY_NUM-1:0]                                tag_we,
    output logic [TAG_WIDTH-1:0]                              tag_wdata,
    output logic                                              dirty_wdata,
    output logic [WORD_WIDTH-1:0]                             load_data,
    output logic                                              load_valid
);

    refill_state_t             state, state_nxt;
    logic [OFFSET_WIDTH-1:0]   cnt;
    logic [TAG_WIDTH-1:0]      lat_tag;
    logic [INDEX_WIDTH-1:0]    lat_index;
    logic [OFFSET_WIDTH-1:0]   lat_offset;
    logic                      lat_wr;
    logic [WORD_WIDTH-1:0]     lat_store_data;
    logic [WAY_IDX_WIDTH-1:0]  lat_way;
    logic [WAY_IDX_WIDTH-1:0]  victim_idx;
    logic [WAY_NUM-1:0]        victim_oh;
    logic                      miss_accept;
    logic                      beat;
    logic                      crit_word;
    logic                      last_word;

    cache_refill_ctrl_way_sel_enc u_way_sel_enc (
        .replace_en ({way3_replace_en_r1, way2_replace_en_r1,
                      way1_replace_en_r1, way0_replace_en_r1}),
        .way_idx    (victim_idx)
    );

    assign victim_oh   = way_onehot(lat_way);
    assign miss_accept = (state == ST_IDLE) && read_main_memory_en_r1;
    assign beat        = (state == ST_FILL) && mem_rvalid;
    assign crit_word   = (cnt == lat_offset);
    assign last_word   = (cnt == OFFSET_WIDTH'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            lat_tag        <= '0;
            lat_index      <= '0;
            lat_offset     <= '0;
            lat_wr         <= 1'b0;
            lat_store_data <= '0;
            lat_way        <= '0;
            load_data      <= '0;
        end else begin
            state <= state_nxt;
            if (miss_accept) begin
                lat_tag        <= tag_r1;
                lat_index      <= index_r1;
                lat_offset     <= offset_r1;
                lat_wr         <= wr_r1;
                lat_store_data <= store_data_r1;
                lat_way        <= victim_idx;
            end
            if (state == ST_REQ && mem_ack) begin
                cnt <= '0;
            end else if (beat) begin
                cnt <= cnt + OFFSET_WIDTH'(1);
            end
            if (beat && !lat_wr && crit_word) begin
                load_data <= mem_rdata;
            end
        end
    end

    // Outputs are qualified with rst_n so the idle pass-through paths
    // (stall, store-hit forwarding) also read zero while reset is held.
    always_comb begin
        state_nxt     = state;
        stall         = 1'b0;
        mem_req       = 1'b0;
        mem_addr      = '0;
        refill_we     = '0;
        refill_index  = '0;
        refill_offset = '0;
        refill_wdata  = '0;
        tag_we        = '0;
        tag_wdata     = '0;
        dirty_wdata   = 1'b0;
        load_valid    = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (read_main_memory_en_r1) begin
                        stall     = 1'b1;
                        state_nxt = ST_REQ;
                    end else if (wr_r1 && (|hit_en_r1)) begin
                        refill_we     = hit_en_r1;
                        refill_index  = index_r1;
                        refill_offset = offset_r1;
                        refill_wdata  = store_data_r1;
                    end
                end
                ST_REQ: begin
                    stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = {lat_tag, lat_index, {OFFSET_WIDTH{1'b0}}, {BYTE_OFF{1'b0}}};
                    if (mem_ack) begin
                        state_nxt = ST_FILL;
                    end
                end
                ST_FILL: begin
                    stall = 1'b1;
                    if (mem_rvalid) begin
                        refill_we     = victim_oh;
                        refill_index  = lat_index;
                        refill_offset = cnt;
                        refill_wdata  = (lat_wr && crit_word) ? lat_store_data : mem_rdata;
                        if (last_word) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    tag_we      = victim_oh;
                    tag_wdata   = lat_tag;
                    dirty_wdata = lat_wr;
                    load_valid  = !lat_wr;
                    state_nxt   = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;
    import cache_refill_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        wr_r1;
    logic [7:0]  tag_r1;
    logic [5:0]  index_r1;
    logic [1:0]  offset_r1;
    logic [31:0] store_data_r1;
    logic [3:0]  hit_en_r1;
    logic        read_main_memory_en_r1;
    logic        way0_replace_en_r1, way1_replace_en_r1, way2_replace_en_r1, way3_replace_en_r1;
    logic        mem_req;
    logic [17:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [3:0]  refill_we;
    logic [5:0]  refill_index;
    logic [1:0]  refill_offset;
    logic [31:0] refill_wdata;
    logic [3:0]  tag_we;
    logic [7:0]  tag_wdata;
    logic        dirty_wdata;
    logic [31:0] load_data;
    logic        load_valid;

    cache_refill_ctrl #(.BYTE_OFF(2)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .wr_r1                  (wr_r1),
        .tag_r1                 (tag_r1),
        .index_r1               (index_r1),
        .offset_r1              (offset_r1),
        .store_data_r1          (store_data_r1),
        .hit_en_r1              (hit_en_r1),
        .read_main_memory_en_r1 (read_main_memory_en_r1),
        .way0_replace_en_r1     (way0_replace_en_r1),
        .way1_replace_en_r1     (way1_replace_en_r1),
        .way2_replace_en_r1     (way2_replace_en_r1),
        .way3_replace_en_r1     (way3_replace_en_r1),
        .mem_req                (mem_req),
        .mem_addr               (mem_addr),
        .mem_ack                (mem_ack),
        .mem_rvalid             (mem_rvalid),
        .mem_rdata              (mem_rdata),
        .stall                  (stall),
        .refill_we              (refill_we),
        .refill_index           (refill_index),
        .refill_offset          (refill_offset),
        .refill_wdata           (refill_wdata),
        .tag_we                 (tag_we),
        .tag_wdata              (tag_wdata),
        .dirty_wdata            (dirty_wdata),
        .load_data              (load_data),
        .load_valid             (load_valid)
    );

    typedef struct packed {
        logic [3:0]  we;
        logic [5:0]  idx;
        logic [1:0]  off;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [3:0] we;
        logic [7:0] tag;
        logic       dirty;
        logic       lv;
    } tag_t;

    wr_t  exp_wr_q[$];
    tag_t exp_tag_q[$];
    wr_t  mon_wr;
    tag_t mon_tag;
    int   n_checks = 0;
    int   n_pass   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every data-array or tag-array write must match the
    // oldest expectation pushed when the corresponding stimulus was driven.
    always @(negedge clk) begin
        if (refill_we !== 4'b0000) begin
            n_checks++;
            if (exp_wr_q.size() == 0) begin
                $display("FAIL refill_write: unexpected we=%b idx=%0d off=%0d data=%h, required no write",
                         refill_we, refill_index, refill_offset, refill_wdata);
            end else begin
                mon_wr = exp_wr_q.pop_front();
                if ({refill_we, refill_index, refill_offset, refill_wdata} !== mon_wr)
                    $display("FAIL refill_write: got we=%b idx=%0d off=%0d data=%h, required we=%b idx=%0d off=%0d data=%h",
                             refill_we, refill_index, refill_offset, refill_wdata,
                             mon_wr.we, mon_wr.idx, mon_wr.off, mon_wr.data);
                else
                    n_pass++;
            end
        end
        if (tag_we !== 4'b0000 || load_valid !== 1'b0) begin
            n_checks++;
            if (exp_tag_q.size() == 0) begin
                $display("FAIL tag_write: unexpected tag_we=%b tag=%h dirty=%b load_valid=%b, required none",
                         tag_we, tag_wdata, dirty_wdata, load_valid);
            end else begin
                mon_tag = exp_tag_q.pop_front();
                if ({tag_we, tag_wdata, dirty_wdata, load_valid} !== mon_tag)
                    $display("FAIL tag_write: got tag_we=%b tag=%h dirty=%b lv=%b, required tag_we=%b tag=%h dirty=%b lv=%b",
                             tag_we, tag_wdata, dirty_wdata, load_valid,
                             mon_tag.we, mon_tag.tag, mon_tag.dirty, mon_tag.lv);
                else
                    n_pass++;
            end
        end
    end

    task automatic clear_inputs();
        wr_r1 = 1'b0; tag_r1 = '0; index_r1 = '0; offset_r1 = '0; store_data_r1 = '0;
        hit_en_r1 = '0; read_main_memory_en_r1 = 1'b0;
        way0_replace_en_r1 = 1'b0; way1_replace_en_r1 = 1'b0;
        way2_replace_en_r1 = 1'b0; way3_replace_en_r1 = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    // Caller is at posedge+1 of an IDLE cycle; returns at posedge+1 of the
    // IDLE cycle following DONE (or following reset release when aborting).
    task automatic do_refill(input string nm, input logic wr, input logic [7:0] tag,
                             input logic [5:0] idx, input logic [1:0] off, input logic [31:0] sd,
                             input logic [3:0] repl, input logic [3:0] exp_way, input int ack_dly,
                             input logic [7:0] gap_mask, input logic noise,
                             input logic [31:0] base, input int abort_after);
        logic [17:0] exp_addr;
        wr_t         w;
        tag_t        t;
        int          k;
        int          cyc;
        exp_addr = {tag, idx, 2'b00, 2'b00};
        read_main_memory_en_r1 = 1'b1;
        wr_r1 = wr; tag_r1 = tag; index_r1 = idx; offset_r1 = off; store_data_r1 = sd;
        {way3_replace_en_r1, way2_replace_en_r1, way1_replace_en_r1, way0_replace_en_r1} = repl;
        hit_en_r1 = '0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || mem_req !== 1'b0)
            $display("FAIL %s idle_miss_stall: stall=%b mem_req=%b, required stall=1 mem_req=0", nm, stall, mem_req);
        else n_pass++;
        @(posedge clk); #1;
        read_main_memory_en_r1 = noise;
        tag_r1 = ~tag; index_r1 = ~idx; wr_r1 = ~wr; offset_r1 = ~off;
        {way3_replace_en_r1, way2_replace_en_r1, way1_replace_en_r1, way0_replace_en_r1} = noise ? 4'b1000 : 4'b0000;
        for (int i = 0; i <= ack_dly; i++) begin
            mem_ack = (i == ack_dly);
            mem_rvalid = noise;
            mem_rdata = 32'hBAD0_0000 | i;
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr || stall !== 1'b1)
                $display("FAIL %s req_hold: mem_req=%b addr=%h stall=%b, required mem_req=1 addr=%h stall=1",
                         nm, mem_req, mem_addr, stall, exp_addr);
            else n_pass++;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            if (cyc < 8 && gap_mask[cyc]) begin
                mem_rvalid = 1'b0;
                mem_rdata = 32'hFFFF_FFFF;
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata = base + k;
                w.we = exp_way; w.idx = idx; w.off = k[1:0];
                w.data = (wr && k[1:0] == off) ? sd : base + k;
                exp_wr_q.push_back(w);
                if (k == 3) begin
                    t.we = exp_way; t.tag = tag; t.dirty = wr; t.lv = ~wr;
                    exp_tag_q.push_back(t);
                end
                k++;
            end
            @(negedge clk);
            n_checks++;
            if (stall !== 1'b1 || mem_req !== 1'b0)
                $display("FAIL %s fill_stall: stall=%b mem_req=%b, required stall=1 mem_req=0", nm, stall, mem_req);
            else n_pass++;
            @(posedge clk); #1;
            cyc++;
            if (abort_after != 0 && k == abort_after) begin
                mem_rvalid = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                n_checks++;
                if ({stall, mem_req, mem_addr, refill_we, refill_index, refill_offset, refill_wdata,
                     tag_we, tag_wdata, dirty_wdata, load_data, load_valid} !== '0)
                    $display("FAIL %s abort_outputs_zero: stall=%b mem_req=%b refill_we=%b tag_we=%b load_data=%h, required all 0",
                             nm, stall, mem_req, refill_we, tag_we, load_data);
                else n_pass++;
                @(posedge clk); #1;
                rst_n = 1'b1;
                clear_inputs();
                return;
            end
        end
        n_checks++;
        if (k < 4) $display("FAIL %s fill_timeout: beats=%0d, required 4", nm, k);
        else n_pass++;
        mem_rvalid = noise;
        mem_rdata = 32'hBAD1_0000;
        read_main_memory_en_r1 = noise;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL %s done_stall: stall=%b mem_req=%b, required 0 0", nm, stall, mem_req);
        else n_pass++;
        if (!wr) begin
            n_checks++;
            if (load_data !== base + off)
                $display("FAIL %s load_data: got %h, required %h", nm, load_data, base + off);
            else n_pass++;
        end
        @(posedge clk); #1;
        clear_inputs();
        n_checks++;
        if (exp_wr_q.size() != 0 || exp_tag_q.size() != 0)
            $display("FAIL %s scoreboard_drained: pending writes=%0d tags=%0d, required 0 0",
                     nm, exp_wr_q.size(), exp_tag_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        read_main_memory_en_r1 = 1'b1;
        wr_r1 = 1'b1; hit_en_r1 = 4'hF; store_data_r1 = 32'h1234_5678; index_r1 = 6'd9;
        @(negedge clk);
        n_checks++;
        if ({stall, mem_req, mem_addr, refill_we, refill_index, refill_offset, refill_wdata,
             tag_we, tag_wdata, dirty_wdata, load_data, load_valid} !== '0)
            $display("FAIL reset_outputs_zero: stall=%b mem_req=%b refill_we=%b tag_we=%b load_data=%h, required all 0",
                     stall, mem_req, refill_we, tag_we, load_data);
        else n_pass++;
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || refill_we !== 4'b0)
            $display("FAIL reset_idle: stall=%b mem_req=%b refill_we=%b, required 0", stall, mem_req, refill_we);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_load_miss();
        do_refill("load_miss", 1'b0, 8'h12, 6'd3, 2'd2, 32'h0, 4'b0100, 4'b0100, 3, 8'h00, 1'b0, 32'h0000_00A0, 0);
    endtask

    task automatic test_store_miss();
        do_refill("store_miss", 1'b1, 8'h34, 6'd5, 2'd1, 32'hDEAD_BEEF, 4'b0001, 4'b0001, 1, 8'h00, 1'b0, 32'h1000_0000, 0);
    endtask

    task automatic test_victim_priority();
        do_refill("victim_w1w3", 1'b0, 8'h56, 6'd7, 2'd0, 32'h0, 4'b1010, 4'b0010, 0, 8'h00, 1'b0, 32'h2000_0000, 0);
        do_refill("victim_none", 1'b1, 8'h78, 6'd8, 2'd3, 32'hCAFE_F00D, 4'b0000, 4'b0001, 2, 8'h00, 1'b0, 32'h3000_0000, 0);
    endtask

    task automatic test_rvalid_gaps();
        do_refill("rvalid_gaps", 1'b0, 8'h9A, 6'd12, 2'd3, 32'h0, 4'b1000, 4'b1000, 2, 8'b0010_0101, 1'b1, 32'h4000_0000, 0);
    endtask

    task automatic test_reset_mid_fill();
        do_refill("reset_abort", 1'b0, 8'hBC, 6'd20, 2'd1, 32'h0, 4'b0100, 4'b0100, 1, 8'h00, 1'b0, 32'h5000_0000, 2);
        do_refill("after_abort", 1'b0, 8'hBD, 6'd20, 2'd0, 32'h0, 4'b0010, 4'b0010, 1, 8'h00, 1'b0, 32'h6000_0000, 0);
    endtask

    task automatic test_back_to_back();
        do_refill("b2b_first", 1'b1, 8'hC1, 6'd30, 2'd2, 32'h1111_2222, 4'b0100, 4'b0100, 0, 8'h00, 1'b0, 32'h7000_0000, 0);
        do_refill("b2b_second", 1'b0, 8'hC2, 6'd31, 2'd1, 32'h0, 4'b1000, 4'b1000, 1, 8'h02, 1'b0, 32'h8000_0000, 0);
    endtask

    task automatic test_store_hit();
        wr_t w;
        wr_r1 = 1'b1; hit_en_r1 = 4'b1000; index_r1 = 6'd7; offset_r1 = 2'd3;
        store_data_r1 = 32'h55AA_1234; read_main_memory_en_r1 = 1'b0;
        w.we = 4'b1000; w.idx = 6'd7; w.off = 2'd3; w.data = 32'h55AA_1234;
        exp_wr_q.push_back(w);
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL store_hit_no_stall: stall=%b mem_req=%b, required 0 0", stall, mem_req);
        else n_pass++;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (exp_wr_q.size() != 0 || refill_we !== 4'b0000)
            $display("FAIL store_hit_one_cycle: pending=%0d refill_we=%b, required 0 0000", exp_wr_q.size(), refill_we);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_load_miss();
        test_store_miss();
        test_victim_priority();
        test_rvalid_gaps();
        test_reset_mid_fill();
        test_back_to_back();
        test_store_hit();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
